// File: rtl/dkong_dma_mc.sv
// Multi-channel memory-to-memory DMA controller.
// Channels are serviced one at a time, lowest index first. Each byte takes
// four granted cycles: address, read, write, then address increment.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no channel active; picks the lowest pending channel and loads it
// REQ    | bus requested; waiting for I_HLDA before moving any data
// XFER   | moving bytes with a 4-phase sequence, frozen while I_HLDA=0
// DONE   | one cycle; pulses O_DONE, drops the bus request, returns to IDLE
module dkong_dma_mc #(
    parameter int NCH = 2,
    parameter int AW  = 10,
    parameter int DW  = 8,
    parameter int CW  = 2
) (
    input  logic              I_CLK,
    input  logic              I_RSTn,
    input  logic              I_CLK_EN,
    input  logic [NCH-1:0]    I_TRIG,
    input  logic [NCH*AW-1:0] I_SRC_BASE,
    input  logic [NCH*AW-1:0] I_DST_BASE,
    input  logic [NCH*AW-1:0] I_LEN,
    input  logic [DW-1:0]     I_DMA_DS,
    input  logic              I_HLDA,
    output logic              O_HRQ,
    output logic [AW-1:0]     O_DMA_AS,
    output logic [AW-1:0]     O_DMA_AD,
    output logic [DW-1:0]     O_DMA_DD,
    output logic              O_DMA_CES,
    output logic              O_DMA_CED,
    output logic              O_DMA_WE,
    output logic [CW-1:0]     O_CH,
    output logic [NCH-1:0]    O_BUSY,
    output logic [NCH-1:0]    O_DONE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state;
    logic [1:0]      phase;
    logic [NCH-1:0]  trig_q;
    logic            primed;
    logic [NCH-1:0]  pending;
    logic            rerun;
    logic [CW-1:0]   ch_r;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   as_r;
    logic [AW-1:0]   ad_r;
    logic [DW-1:0]   dd_r;
    logic            hrq_r;
    logic            ces_r;
    logic            ced_r;
    logic [NCH-1:0]  done_r;

    logic [NCH-1:0]  trig_edge;
    logic [NCH-1:0]  ch_mask;
    logic            any_pend;
    logic [CW-1:0]   sel_idx;
    logic [AW-1:0]   sel_src;
    logic [AW-1:0]   sel_dst;
    logic [AW-1:0]   sel_len;

    // Edge detection is suppressed for the first enabled cycle after reset so a
    // trigger held high through reset is treated as history, not as a new edge.
    assign trig_edge = primed ? (I_TRIG & ~trig_q) : '0;
    assign ch_mask   = NCH'(1) << ch_r;

    // Lowest-index pending channel and its programmed transfer parameters.
    always_comb begin
        any_pend = 1'b0;
        sel_idx  = '0;
        sel_src  = '0;
        sel_dst  = '0;
        sel_len  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                any_pend = 1'b1;
                sel_idx  = CW'(i);
                sel_src  = I_SRC_BASE[i*AW +: AW];
                sel_dst  = I_DST_BASE[i*AW +: AW];
                sel_len  = I_LEN[i*AW +: AW];
            end
        end
    end

    // Controller FSM, trigger bookkeeping and all registered outputs.
    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state   <= S_IDLE;
            phase   <= 2'd0;
            trig_q  <= '0;
            primed  <= 1'b0;
            pending <= '0;
            rerun   <= 1'b0;
            ch_r    <= '0;
            cnt     <= '0;
            as_r    <= '0;
            ad_r    <= '0;
            dd_r    <= '0;
            hrq_r   <= 1'b0;
            ces_r   <= 1'b0;
            ced_r   <= 1'b0;
            done_r  <= '0;
        end else if (I_CLK_EN) begin
            primed  <= 1'b1;
            trig_q  <= I_TRIG;
            done_r  <= '0;
            pending <= pending | trig_edge;
            case (state)
                S_IDLE: begin
                    if (any_pend) begin
                        ch_r  <= sel_idx;
                        cnt   <= sel_len;
                        as_r  <= sel_src;
                        ad_r  <= sel_dst;
                        hrq_r <= 1'b1;
                        ces_r <= 1'b1;
                        ced_r <= 1'b1;
                        rerun <= trig_edge[sel_idx];
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (trig_edge[ch_r]) rerun <= 1'b1;
                    if (I_HLDA) begin
                        phase <= 2'd0;
                        state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (trig_edge[ch_r]) rerun <= 1'b1;
                    if (I_HLDA) begin
                        phase <= phase + 2'd1;
                        case (phase)
                            2'd1: dd_r <= I_DMA_DS;
                            2'd3: begin
                                as_r <= as_r + AW'(1);
                                ad_r <= ad_r + AW'(1);
                                if (cnt == '0) state <= S_DONE;
                                else           cnt   <= cnt - AW'(1);
                            end
                            default: ;
                        endcase
                    end
                end
                S_DONE: begin
                    // A retrigger seen while active, or an edge this very cycle,
                    // keeps the channel pending so it runs again.
                    pending[ch_r] <= rerun | trig_edge[ch_r];
                    done_r        <= ch_mask;
                    hrq_r         <= 1'b0;
                    ces_r         <= 1'b0;
                    ced_r         <= 1'b0;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The write strobe is gated by the grant so a stall removes it immediately.
    assign O_DMA_WE  = (state == S_XFER) && (phase == 2'd2) && I_HLDA;
    assign O_HRQ     = hrq_r;
    assign O_DMA_AS  = as_r;
    assign O_DMA_AD  = ad_r;
    assign O_DMA_DD  = dd_r;
    assign O_DMA_CES = ces_r;
    assign O_DMA_CED = ced_r;
    assign O_CH      = ch_r;
    assign O_DONE    = done_r;
    assign O_BUSY    = pending | ((state != S_IDLE) ? ch_mask : '0);

endmodule

// File: tb/tb_dkong_dma_mc.sv
// Self-checking bench for dkong_dma_mc: expected writes and completions are
// queued when a transfer is set up and popped as the DUT produces them.
module tb_dkong_dma_mc;
    localparam int NCH = 2;
    localparam int AW  = 10;
    localparam int DW  = 8;
    localparam int CW  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clk_en = 1'b1;
    logic [NCH-1:0]    trig = '0;
    logic [NCH*AW-1:0] src_base = '0;
    logic [NCH*AW-1:0] dst_base = '0;
    logic [NCH*AW-1:0] len = '0;
    logic [DW-1:0]     ds;
    logic              hlda = 1'b1;
    logic              hrq;
    logic [AW-1:0]     as_o;
    logic [AW-1:0]     ad_o;
    logic [DW-1:0]     dd_o;
    logic              ces;
    logic              ced;
    logic              we;
    logic [CW-1:0]     ch;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    done;

    dkong_dma_mc #(.NCH(NCH), .AW(AW), .DW(DW), .CW(CW)) dut (
        .I_CLK      (clk),
        .I_RSTn     (rst_n),
        .I_CLK_EN   (clk_en),
        .I_TRIG     (trig),
        .I_SRC_BASE (src_base),
        .I_DST_BASE (dst_base),
        .I_LEN      (len),
        .I_DMA_DS   (ds),
        .I_HLDA     (hlda),
        .O_HRQ      (hrq),
        .O_DMA_AS   (as_o),
        .O_DMA_AD   (ad_o),
        .O_DMA_DD   (dd_o),
        .O_DMA_CES  (ces),
        .O_DMA_CED  (ced),
        .O_DMA_WE   (we),
        .O_CH       (ch),
        .O_BUSY     (busy),
        .O_DONE     (done)
    );

    always #5 clk = ~clk;

    // Source memory: data is a fixed scramble of the address.
    function automatic logic [DW-1:0] src_data(input logic [AW-1:0] a);
        return a[7:0] ^ {a[9:8], 6'h15};
    endfunction
    assign ds = src_data(as_o);

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] as;
        logic [AW-1:0] ad;
        logic [DW-1:0] dd;
    } wr_t;

    wr_t wr_q[$];
    int  done_q[$];
    int  en_div = 1;
    int  wr_count = 0;
    int  gcount = 0;
    int  rcount = 0;
    int  done_count = 0;

    // Clock-enable pattern: high on every en_div-th clock.
    initial begin
        int n = 0;
        forever begin
            @(posedge clk);
            #1;
            n++;
            clk_en = ((n % en_div) == 0);
        end
    end

    // Raw clocks with the bus held, for the clock-enable scaling check.
    always @(negedge clk) begin
        if (rst_n && hrq && hlda) rcount++;
    end

    // Scoreboard: every write strobe and done pulse on an enabled cycle.
    always @(negedge clk) begin
        wr_t e;
        int  c;
        if (rst_n && clk_en) begin
            if (hrq && hlda) gcount++;
            if (we) begin
                wr_count++;
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", we, 1'b0);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_as", as_o, e.as);
                    check("wr_ad", ad_o, e.ad);
                    check("wr_dd", dd_o, e.dd);
                end
            end
            if (done != '0) begin
                done_count++;
                check("done_hrq_low", hrq, 1'b0);
                if (done_q.size() == 0) begin
                    check("done_unexpected", done, '0);
                end else begin
                    c = done_q.pop_front();
                    check("done_ch", done, 32'(1) << c);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk iff clk_en);
        #1;
    endtask

    task automatic setup(input int c, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW-1:0] l);
        wr_t e;
        logic [AW-1:0] a;
        src_base[c*AW +: AW] = s;
        dst_base[c*AW +: AW] = d;
        len[c*AW +: AW]      = l;
        for (int k = 0; k <= int'(l); k++) begin
            a    = s + AW'(k);
            e.as = a;
            e.ad = d + AW'(k);
            e.dd = src_data(a);
            wr_q.push_back(e);
        end
        done_q.push_back(c);
    endtask

    task automatic trig_pulse(input logic [NCH-1:0] m);
        trig = trig | m;
        cyc(2);
        trig = trig & ~m;
        cyc(1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while ((done_q.size() != 0 || wr_q.size() != 0) && n < budget) begin
            cyc(1);
            n++;
        end
        check({tag, "_wr_left"}, wr_q.size(), 0);
        check({tag, "_done_left"}, done_q.size(), 0);
        cyc(2);
    endtask

    task automatic wait_wr(input string tag, input int target, input int budget);
        int n = 0;
        while (wr_count < target && n < budget) begin
            cyc(1);
            n++;
        end
        check({tag, "_reached"}, wr_count >= target, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hrq"}, hrq, 0);
        check({tag, "_as"}, as_o, 0);
        check({tag, "_ad"}, ad_o, 0);
        check({tag, "_dd"}, dd_o, 0);
        check({tag, "_ces"}, ces, 0);
        check({tag, "_ced"}, ced, 0);
        check({tag, "_we"}, we, 0);
        check({tag, "_ch"}, ch, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(3);

        // Long transfer with the bus always granted; base change mid-run ignored.
        gcount = 0; wr_count = 0; done_count = 0;
        setup(0, 10'h100, 10'h000, 10'h17F);
        trig_pulse(2'b01);
        check("t1_hrq", hrq, 1);
        check("t1_busy", busy, 2'b01);
        check("t1_ces", ces, 1);
        src_base[0 +: AW] = 10'h3AA;
        dst_base[0 +: AW] = 10'h055;
        wait_done("t1", 2000);
        check("t1_writes", wr_count, 384);
        check("t1_grant", gcount, 4 * 384 + 2);
        check("t1_done_cnt", done_count, 1);
        check("t1_final_as", as_o, 10'h280);
        check("t1_final_ad", ad_o, 10'h180);
        check("t1_final_dd", dd_o, src_data(10'h27F));
        check("t1_idle_hrq", hrq, 0);
        check("t1_idle_busy", busy, 0);

        // Simultaneous triggers: ch0 first, one idle-bus cycle, then ch1.
        done_count = 0;
        setup(0, 10'h020, 10'h200, 10'd3);
        setup(1, 10'h040, 10'h300, 10'd2);
        trig_pulse(2'b11);
        check("t2_busy_both", busy, 2'b11);
        check("t2_ch0", ch, 0);
        n = 0;
        while (done_count < 1 && n < 100) begin
            cyc(1);
            n++;
        end
        check("t2_ch1_hrq", hrq, 1);
        check("t2_ch1_sel", ch, 1);
        wait_done("t2", 100);
        check("t2_done_cnt", done_count, 2);

        // Grant withdrawn for 5 cycles in the write phase of byte 3.
        gcount = 0; wr_count = 0;
        setup(0, 10'h150, 10'h050, 10'd5);
        trig_pulse(2'b01);
        wait_wr("t3_b3", 3, 100);
        n = 0;
        while (!we && n < 10) begin
            cyc(1);
            n++;
        end
        check("t3_we_seen", we, 1);
        hlda = 1'b0;
        #1;
        check("t3_we_drop", we, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("t3_stall_we", we, 0);
            check("t3_stall_hrq", hrq, 1);
        end
        hlda = 1'b1;
        wait_done("t3", 100);
        check("t3_writes", wr_count, 6);
        check("t3_grant", gcount, 4 * 6 + 2);

        // Source address wrap, plus a retrigger while the channel is active.
        wr_count = 0; done_count = 0;
        setup(1, 10'h3FE, 10'h010, 10'd3);
        trig_pulse(2'b10);
        setup(1, 10'h3FE, 10'h010, 10'd3);
        trig_pulse(2'b10);
        wait_done("t4", 200);
        check("t4_writes", wr_count, 8);
        check("t4_done_cnt", done_count, 2);
        check("t4_final_as", as_o, 10'h002);
        check("t4_final_ad", ad_o, 10'h014);

        // Reset in the middle of a transfer, trigger held high across it.
        wr_count = 0; done_count = 0;
        setup(0, 10'h100, 10'h000, 10'h17F);
        trig = 2'b01;
        wait_wr("t5_b10", 10, 200);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_rst");
        wr_q.delete();
        done_q.delete();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc(5);
        check("t5_held_hrq", hrq, 0);
        check("t5_held_busy", busy, 0);
        check("t5_no_done", done_count, 0);
        trig = 2'b00;
        cyc(2);
        wr_count = 0;
        setup(0, 10'h100, 10'h000, 10'h17F);
        trig_pulse(2'b01);
        wait_done("t5", 2000);
        check("t5_writes", wr_count, 384);
        check("t5_final_as", as_o, 10'h280);

        // Same long transfer with the clock enabled one clock in three.
        en_div = 3;
        cyc(2);
        gcount = 0; rcount = 0; wr_count = 0; done_count = 0;
        setup(0, 10'h100, 10'h000, 10'h17F);
        trig_pulse(2'b01);
        wait_done("t6", 2000);
        check("t6_writes", wr_count, 384);
        check("t6_grant", gcount, 4 * 384 + 2);
        check("t6_raw", rcount, 3 * (4 * 384 + 2));
        check("t6_done_cnt", done_count, 1);
        check("t6_final_as", as_o, 10'h280);
        check("t6_final_ad", ad_o, 10'h180);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dkong_dma_mc.md
DKONG_DMA_MC -- requirements
Module: dkong_dma_mc

Interface
REQ-001 SHALL provide parameters (name, default, meaning):
- NCH, 2, number of DMA channels (1..4)
- AW, 10, address width of source and destination buses
- DW, 8, data width
- CW, 2, channel-index width; CW >= clog2(NCH), and CW >= 1
REQ-002 SHALL provide ports (name, direction, width, meaning):
- I_CLK, in, 1, sole clock
- I_RSTn, in, 1, reset, asynchronous, active-low
- I_CLK_EN, in, 1, clock enable; all state advances only when high
- I_TRIG, in, NCH, per-channel start request, rising-edge sensitive
- I_SRC_BASE, in, NCH*AW, per-channel source start address; channel n at [n*AW +: AW]
- I_DST_BASE, in, NCH*AW, per-channel destination start address
- I_LEN, in, NCH*AW, per-channel byte count minus one
- I_DMA_DS, in, DW, source read data
- I_HLDA, in, 1, bus grant from CPU
- O_HRQ, out, 1, bus request
- O_DMA_AS, out, AW, source address
- O_DMA_AD, out, AW, destination address
- O_DMA_DD, out, DW, destination write data
- O_DMA_CES, out, 1, source chip enable
- O_DMA_CED, out, 1, destination chip enable
- O_DMA_WE, out, 1, destination write strobe
- O_CH, out, CW, index of the active channel
- O_BUSY, out, NCH, channel pending or active
- O_DONE, out, NCH, one-enabled-cycle completion pulse

Function
REQ-003 SHALL define a "cycle" as a rising I_CLK edge with I_CLK_EN=1; when I_CLK_EN=0 all registers and outputs SHALL hold.
REQ-004 SHALL detect a trigger per channel as a 0->1 transition between consecutive cycles, and SHALL set that channel's pending bit.
REQ-005 SHALL set O_BUSY[n] while channel n is pending or active.
REQ-006 SHALL implement the states IDLE, REQ, XFER and DONE.
REQ-007 IDLE: when any channel is pending, SHALL select the lowest-index pending channel, load the byte counter from I_LEN[n], AS from I_SRC_BASE[n] and AD from I_DST_BASE[n], drive O_CH=n, assert O_HRQ, CES and CED, and go to REQ.
REQ-008 REQ: SHALL wait for I_HLDA=1, then go to XFER at phase 0.
REQ-009 XFER SHALL run a 2-bit phase counter that advances only in cycles with I_HLDA=1:
- phase 0: addresses stable
- phase 1: DD <= I_DMA_DS
- phase 2: O_DMA_WE=1 for that cycle only
- phase 3: AS and AD each increment by 1, modulo 2^AW (wrap, no error), and the counter decrements
REQ-010 If I_HLDA drops during XFER, the block SHALL freeze phase, addresses and data, keep O_HRQ=1 and force O_DMA_WE=0, then resume at the same phase when I_HLDA returns.
REQ-011 When phase 3 executes with the counter at 0, SHALL go to DONE; a full transfer SHALL take exactly 4*(LEN+1) granted cycles.
REQ-012 DONE (one cycle): SHALL pulse O_DONE[n], clear pending bit n, deassert O_HRQ, CES and CED, and return to IDLE.
REQ-013 If another channel is pending at DONE, the next transfer SHALL start from IDLE on the following cycle, so HRQ is low for at least one cycle between channels.
REQ-014 A trigger on the active channel during REQ or XFER SHALL set its pending bit again, re-running the channel after DONE. DONE's clear SHALL lose to a same-cycle trigger edge (trigger wins).
REQ-015 Base and length inputs SHALL be sampled only at the IDLE load; later changes SHALL not affect a running transfer.
REQ-016 Triggers on several channels in the same cycle SHALL all be latched and serviced in ascending index order.
REQ-017 O_DMA_DD SHALL hold its last value outside phase 1.

Reset
REQ-018 I_RSTn=0 SHALL asynchronously force IDLE, clear pending and edge history, and drive all outputs to 0 (AS, AD, DD, O_CH included), independent of I_CLK_EN.
REQ-019 Reset asserted mid-transfer SHALL abort without an O_DONE pulse. After release, a trigger held high SHALL not start a transfer until it falls and rises again.

Verification
REQ-020 Channel 0 with SRC=0x100, DST=0x000, LEN=0x17F, HLDA tied 1, one trigger edge -> HRQ high; 384 WE pulses; dest k receives src 0x100+k; final AS=0x280, AD=0x180; O_DONE[0] pulses after 1536 XFER cycles.
REQ-021 Triggers on ch0 and ch1 in the same cycle -> ch0 completes, HRQ low 1 cycle, then ch1 runs with O_CH=1; two separate DONE pulses.
REQ-022 HLDA toggled low for 5 cycles in phase 2 of byte 3 -> WE low while stalled; byte 3 written exactly once; total granted cycles unchanged.
REQ-023 SRC=0x3FE, LEN=3 with AW=10 -> source addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-024 I_RSTn pulsed low at byte 10 -> all outputs 0 immediately, no DONE; a new trigger edge restarts from base.
REQ-025 I_CLK_EN=1 every 3rd clock -> same results as REQ-020, timing scaled by 3.
